// File: rtl/oe_sort_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oe_sort_pkg
// Description : Shared types and helpers for the odd-even sort buffer:
//               control-state encoding, DEPTH legality check and the
//               pass-parity helper that selects the even/odd pairing.
// Revision    : 1.0 - initial release
// ============================================================================
package oe_sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // The pairing scheme needs whole pairs on the even pass.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth % 2) == 0);
  endfunction

  // Odd passes pair (1,2),(3,4)...; even passes pair (0,1),(2,3)...
  function automatic logic pass_is_odd(input int unsigned pass);
    return (pass % 2) == 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oe_sort_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : oe_sort_buffer_if
// Description : Burst-in / sorted-stream-out valid/ready bundle.
//               master = producer/consumer side, slave = sort buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface oe_sort_buffer_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/oe_sort_buffer_minmax.sv
`default_nettype none
// ============================================================================
// Module      : minmax_cell
// Description : Combinational unsigned compare-exchange cell. Equal operands
//               pass straight through (no swap reported).
// Revision    : 1.0 - initial release
// ============================================================================
module minmax_cell #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swapped
);

  // Strict compare so ties keep their original positions.
  assign swapped = (y < x);
  assign lo      = swapped ? y : x;
  assign hi      = swapped ? x : y;

endmodule
`default_nettype wire

// File: rtl/oe_sort_buffer.sv
`default_nettype none
// ============================================================================
// Module      : oe_sort_buffer
// Description : Collects a burst of DEPTH words, sorts it in place with one
//               odd-even transposition pass per cycle, then streams the words
//               out smallest first with out_last on the largest.
//               Optional macro OE_SORT_BUFFER_EARLY_EXIT_EN: leave SORT once
//               two consecutive passes perform no swap.
// Revision    : 1.0 - initial release
// ============================================================================
module oe_sort_buffer
  import oe_sort_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  oe_sort_buffer_if.slave bus
);

  localparam int               c_pairs = DEPTH / 2;
  localparam logic [CNT_W-1:0] c_last  = CNT_W'(DEPTH - 1);

  if (!depth_ok(DEPTH)) begin : g_depth_check
    $fatal(1, "oe_sort_buffer: DEPTH must be even and at least 2");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] w_idx_next;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] w_pass_next;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_sort_done;
  logic             w_odd;

  logic [WIDTH-1:0] r_buf    [DEPTH];
  logic [WIDTH-1:0] w_sorted [DEPTH];
  logic [WIDTH-1:0] w_x      [c_pairs];
  logic [WIDTH-1:0] w_y      [c_pairs];
  logic [WIDTH-1:0] w_lo     [c_pairs];
  logic [WIDTH-1:0] w_hi     [c_pairs];
  logic [c_pairs-1:0] w_swap;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;
  assign w_odd      = pass_is_odd(32'(r_pass));

  // Cell operand steering: on odd passes each cell shifts up by one word;
  // the top cell has no odd partner and its result is discarded then.
  for (genvar k = 0; k < c_pairs; k++) begin : g_cell
    if (k < c_pairs - 1) begin : g_inner
      assign w_x[k] = w_odd ? r_buf[2*k+1] : r_buf[2*k];
      assign w_y[k] = w_odd ? r_buf[2*k+2] : r_buf[2*k+1];
    end else begin : g_top
      assign w_x[k] = r_buf[2*k];
      assign w_y[k] = r_buf[2*k+1];
    end

    minmax_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .x       (w_x[k]),
      .y       (w_y[k]),
      .lo      (w_lo[k]),
      .hi      (w_hi[k]),
      .swapped (w_swap[k])
    );
  end

  // Result gather: each word takes its value from whichever cell covers it
  // in the current pass; the end words are idle on odd passes.
  for (genvar j = 0; j < DEPTH; j++) begin : g_gather
    if (j == 0) begin : g_first
      assign w_sorted[j] = w_odd ? r_buf[j] : w_lo[0];
    end else if (j == DEPTH - 1) begin : g_last
      assign w_sorted[j] = w_odd ? r_buf[j] : w_hi[j/2];
    end else if ((j % 2) == 0) begin : g_even
      assign w_sorted[j] = w_odd ? w_hi[j/2-1] : w_lo[j/2];
    end else begin : g_odd
      assign w_sorted[j] = w_odd ? w_lo[j/2] : w_hi[j/2];
    end
  end

`ifdef OE_SORT_BUFFER_EARLY_EXIT_EN
  logic [c_pairs-1:0] w_live_swap;
  logic               w_any_swap;
  logic               r_prev_clean;

  // Swap flag for the current pass, ignoring the idle top cell on odd passes.
  always_comb begin
    w_live_swap = w_swap;
    if (w_odd) begin
      w_live_swap[c_pairs-1] = 1'b0;
    end
    w_any_swap = |w_live_swap;
  end

  // Remembers whether the previous pass of this burst was swap-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_clean <= 1'b0;
    end else if (r_state == SORT) begin
      r_prev_clean <= ~w_any_swap;
    end else begin
      r_prev_clean <= 1'b0;
    end
  end

  assign w_sort_done = (r_pass == c_last) ||
                       ((r_pass != '0) && r_prev_clean && !w_any_swap);
`else
  logic w_unused_swap;

  // Swap flags have no consumer without early exit; tie them off.
  assign w_unused_swap = ^w_swap;
  assign w_sort_done   = (r_pass == c_last);
`endif

  // Next-state and counter decode for the LOAD -> SORT -> DRAIN cycle.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_pass_next  = r_pass;
    case (r_state)
      LOAD: begin
        if (w_in_fire) begin
          if (r_idx == c_last) begin
            w_state_next = SORT;
            w_idx_next   = '0;
            w_pass_next  = '0;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      SORT: begin
        if (w_sort_done) begin
          w_state_next = DRAIN;
          w_pass_next  = '0;
        end else begin
          w_pass_next = r_pass + 1'b1;
        end
      end
      DRAIN: begin
        if (w_out_fire) begin
          if (r_idx == c_last) begin
            w_state_next = LOAD;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = LOAD;
        w_idx_next   = '0;
        w_pass_next  = '0;
      end
    endcase
  end

  // State, counters and registered handshake flags. out_valid lags DRAIN
  // entry by one edge so the last pass result is settled before it is shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_idx       <= '0;
      r_pass      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_pass      <= w_pass_next;
      r_in_ready  <= (w_state_next == LOAD);
      r_out_valid <= (r_state == DRAIN) && (w_state_next == DRAIN);
    end
  end

  // Word storage: written by the loader, rewritten by each sort pass.
  always_ff @(posedge clk) begin
    if ((r_state == LOAD) && w_in_fire) begin
      r_buf[r_idx] <= bus.in_data;
    end else if (r_state == SORT) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= w_sorted[i];
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_valid ? r_buf[r_idx] : '0;
  assign bus.out_last  = r_out_valid && (r_idx == c_last);
  assign bus.busy      = (r_state != LOAD);

endmodule
`default_nettype wire
